// File: rtl/fib_bcd.sv
// fib_bcd: iterative binary-to-packed-BCD converter (double-dabble, one bit per clock).
// Accepts a wide unsigned value over valid/ready and returns its decimal digits plus a
// significant-digit count over a second valid/ready handshake.
module fib_bcd #(
  parameter int unsigned IN_WIDTH = 180,
  parameter int unsigned DIGITS   = 55,
  parameter int unsigned CNT_W    = $clog2(DIGITS + 1)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  vld_in,
  output logic                  rdy_in,
  input  logic [IN_WIDTH-1:0]   bin_in,
  output logic                  vld_out,
  input  logic                  rdy_out,
  output logic [4*DIGITS-1:0]   bcd_out,
  output logic [CNT_W-1:0]      num_digits
);

  localparam int unsigned BcdW = 4 * DIGITS;
  localparam int unsigned BitW = $clog2(IN_WIDTH + 1);

  typedef enum logic [1:0] {StIdle, StConv, StDone} state_e;

  state_e              state_q;
  logic [IN_WIDTH-1:0] shreg_q;
  logic [BitW-1:0]     cnt_q;
  logic [BcdW-1:0]     bcd_q;
  logic [BcdW-1:0]     bcd_adj;

  // Add-3 correction on every digit >= 5, applied to all digits in parallel before the shift.
  always_comb begin
    bcd_adj = bcd_q;
    for (int k = 0; k < int'(DIGITS); k++) begin
      if (bcd_q[4*k +: 4] >= 4'd5) begin
        bcd_adj[4*k +: 4] = bcd_q[4*k +: 4] + 4'd3;
      end
    end
  end

  // Control FSM and datapath; handshake outputs are registered alongside the state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      shreg_q <= '0;
      cnt_q   <= '0;
      bcd_q   <= '0;
      rdy_in  <= 1'b1;
      vld_out <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (vld_in) begin
            shreg_q <= bin_in;
            bcd_q   <= '0;
            cnt_q   <= BitW'(IN_WIDTH);
            rdy_in  <= 1'b0;
            state_q <= StConv;
          end
        end
        StConv: begin
          // MSB of the binary shift register enters BCD bit 0.
          bcd_q   <= {bcd_adj[BcdW-2:0], shreg_q[IN_WIDTH-1]};
          shreg_q <= {shreg_q[IN_WIDTH-2:0], 1'b0};
          cnt_q   <= cnt_q - BitW'(1);
          if (cnt_q == BitW'(1)) begin
            vld_out <= 1'b1;
            state_q <= StDone;
          end
        end
        StDone: begin
          // Return to idle first; a pending vld_in is accepted on the following edge.
          if (rdy_out) begin
            vld_out <= 1'b0;
            rdy_in  <= 1'b1;
            state_q <= StIdle;
          end
        end
        default: begin
          rdy_in  <= 1'b1;
          vld_out <= 1'b0;
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign bcd_out = bcd_q;

  // Priority encode of the highest nonzero digit, plus one; a zero result reports one digit.
  always_comb begin
    num_digits = CNT_W'(1);
    for (int k = 0; k < int'(DIGITS); k++) begin
      if (bcd_q[4*k +: 4] != 4'd0) begin
        num_digits = CNT_W'(k + 1);
      end
    end
  end

endmodule

// File: tb/tb_fib_bcd.sv
// Directed testbench for fib_bcd: handshake timing, digit conversion, backpressure,
// asynchronous reset mid-conversion and a Fibonacci chain against a division-based model.
module tb_fib_bcd;

  localparam int unsigned InW = 180;
  localparam int unsigned Dig = 55;
  localparam int unsigned CntW = $clog2(Dig + 1);

  logic             clk;
  logic             rst_n;
  logic             vld_in;
  logic             rdy_in;
  logic [InW-1:0]   bin_in;
  logic             vld_out;
  logic             rdy_out;
  logic [4*Dig-1:0] bcd_out;
  logic [CntW-1:0]  num_digits;

  int passed;
  int total;

  fib_bcd #(.IN_WIDTH(InW), .DIGITS(Dig)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .vld_in    (vld_in),
    .rdy_in    (rdy_in),
    .bin_in    (bin_in),
    .vld_out   (vld_out),
    .rdy_out   (rdy_out),
    .bcd_out   (bcd_out),
    .num_digits(num_digits)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference decimal conversion by repeated division (independent of the shift-add method).
  function automatic logic [4*Dig-1:0] ref_bcd(input logic [InW-1:0] v);
    logic [4*Dig-1:0] r;
    logic [InW-1:0]   t;
    r = '0;
    t = v;
    for (int k = 0; k < int'(Dig); k++) begin
      r[4*k +: 4] = 4'(t % 10);
      t = t / 10;
    end
    return r;
  endfunction

  function automatic int ref_nd(input logic [InW-1:0] v);
    int n;
    logic [InW-1:0] t;
    n = 0;
    t = v;
    while (t != 0) begin
      t = t / 10;
      n++;
    end
    return (n == 0) ? 1 : n;
  endfunction

  // Present v at a negedge, wait for the accept edge, then count edges until vld_out.
  task automatic start_and_wait(input logic [InW-1:0] v, output int lat);
    int w;
    bin_in = v;
    vld_in = 1'b1;
    w = 0;
    while (!rdy_in && w < 20) begin
      @(negedge clk);
      w++;
    end
    @(posedge clk);
    @(negedge clk);
    vld_in = 1'b0;
    lat = 0;
    while (!vld_out && lat < 400) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic release_result();
    rdy_out = 1'b1;
    @(negedge clk);
    rdy_out = 1'b0;
  endtask

  task automatic check_result(input string name, input logic [4*Dig-1:0] exp_bcd,
                              input int exp_nd);
    total++;
    if (vld_out !== 1'b1) $display("FAIL %s vld_out: got %b want 1", name, vld_out);
    else passed++;
    total++;
    if (bcd_out !== exp_bcd) $display("FAIL %s bcd_out: got %h want %h", name, bcd_out, exp_bcd);
    else passed++;
    total++;
    if (num_digits !== CntW'(exp_nd))
      $display("FAIL %s num_digits: got %0d want %0d", name, num_digits, exp_nd);
    else passed++;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    vld_in = 1'b0;
    rdy_out = 1'b0;
    bin_in = '0;
    repeat (3) @(negedge clk);
    total++;
    if ({rdy_in, vld_out} !== 2'b10)
      $display("FAIL reset handshake: got rdy_in=%b vld_out=%b want 1/0", rdy_in, vld_out);
    else passed++;
    total++;
    if (bcd_out !== '0 || num_digits !== CntW'(1))
      $display("FAIL reset outputs: got bcd=%h nd=%0d want 0/1", bcd_out, num_digits);
    else passed++;
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_zero();
    int lat;
    start_and_wait('0, lat);
    total++;
    if (lat !== 180) $display("FAIL zero latency: got %0d want 180", lat);
    else passed++;
    check_result("zero", '0, 1);
    release_result();
    total++;
    if ({rdy_in, vld_out} !== 2'b10)
      $display("FAIL zero release: got rdy_in=%b vld_out=%b want 1/0", rdy_in, vld_out);
    else passed++;
  endtask

  task automatic test_small();
    int lat;
    start_and_wait(InW'(144), lat);
    check_result("dec144", 220'h144, 3);
    release_result();
    start_and_wait(InW'(99), lat);
    check_result("dec99", 220'h099, 2);
    release_result();
    start_and_wait(InW'(100), lat);
    check_result("dec100", 220'h100, 3);
    release_result();
  endtask

  task automatic test_large();
    int lat;
    logic [4*Dig-1:0] e;
    e = '0;
    e[72] = 1'b1;
    start_and_wait(InW'(64'd1000000000000000000), lat);
    check_result("pow10_18", e, 19);
    release_result();
    start_and_wait(InW'(64'hFFFF_FFFF_FFFF_FFFF), lat);
    check_result("u64max", 220'h18446744073709551615, 20);
    total++;
    if (lat !== 180) $display("FAIL u64max latency: got %0d want 180", lat);
    else passed++;
    release_result();
  endtask

  task automatic test_backpressure();
    int lat;
    int bad;
    start_and_wait(InW'(777), lat);
    check_result("bp_first", 220'h777, 3);
    bad = 0;
    bin_in = InW'(321);
    for (int i = 0; i < 25; i++) begin
      vld_in = i[0];
      @(negedge clk);
      if (bcd_out !== 220'h777 || rdy_in !== 1'b0 || vld_out !== 1'b1) bad++;
    end
    total++;
    if (bad != 0) $display("FAIL bp_hold: got %0d bad cycles want 0", bad);
    else passed++;
    vld_in = 1'b1;
    release_result();
    total++;
    if ({rdy_in, vld_out} !== 2'b10 || bcd_out !== 220'h777)
      $display("FAIL bp_idle: got rdy_in=%b vld_out=%b bcd=%h want 1/0/777",
               rdy_in, vld_out, bcd_out);
    else passed++;
    @(negedge clk);
    vld_in = 1'b0;
    total++;
    if (rdy_in !== 1'b0 || bcd_out !== '0)
      $display("FAIL bp_accept: got rdy_in=%b bcd=%h want 0/0", rdy_in, bcd_out);
    else passed++;
    lat = 0;
    while (!vld_out && lat < 400) begin
      @(negedge clk);
      lat++;
    end
    check_result("bp_second", 220'h321, 3);
    release_result();
  endtask

  task automatic test_reset_mid();
    int lat;
    bin_in = InW'(12345);
    vld_in = 1'b1;
    @(posedge clk);
    @(negedge clk);
    vld_in = 1'b0;
    repeat (50) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    total++;
    if ({rdy_in, vld_out} !== 2'b10 || bcd_out !== '0)
      $display("FAIL mid_reset: got rdy_in=%b vld_out=%b bcd=%h want 1/0/0",
               rdy_in, vld_out, bcd_out);
    else passed++;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    start_and_wait(InW'(255), lat);
    check_result("after_reset", 220'h255, 3);
    total++;
    if (lat !== 180) $display("FAIL after_reset latency: got %0d want 180", lat);
    else passed++;
    release_result();
  endtask

  task automatic test_fib_chain();
    logic [InW-1:0] a;
    logic [InW-1:0] b;
    logic [InW-1:0] t;
    int lat;
    int bad;
    a = '0;
    b = InW'(1);
    bad = 0;
    for (int i = 0; i < 256; i++) begin
      start_and_wait(a, lat);
      total++;
      if (vld_out !== 1'b1 || bcd_out !== ref_bcd(a) || num_digits !== CntW'(ref_nd(a))) begin
        $display("FAIL fib%0d: got bcd=%h nd=%0d want %h nd=%0d", i, bcd_out, num_digits,
                 ref_bcd(a), ref_nd(a));
        bad++;
      end else passed++;
      if (i == 255) begin
        total++;
        if (num_digits !== CntW'(53)) $display("FAIL fib255 nd: got %0d want 53", num_digits);
        else passed++;
      end
      release_result();
      t = a + b;
      a = b;
      b = t;
    end
  endtask

  initial begin
    passed = 0;
    total = 0;
    test_reset();
    test_zero();
    test_small();
    test_large();
    test_backpressure();
    test_reset_mid();
    test_fib_chain();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
